// File: rtl/mul_pipe.sv
// mul_pipe: pipelined MUL/MULH/MULHSU/MULHU built on a row-level Wallace (3:2 carry-save) tree.
// Optional MUL_EARLY_OUT_EN: a zero operand accepted into an idle pipe retires after one cycle.
module mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int PW  = 2*WIDTH + 2;
  localparam int NPP = WIDTH + 2;
  localparam int HW  = 2*WIDTH;

  typedef logic [NPP-1:0][PW-1:0] rows_t;

  function automatic int count_levels(input int n);
    int m, l;
    m = n;
    l = 0;
    while (m > 2) begin
      m = 2*(m/3) + m%3;
      l++;
    end
    return l;
  endfunction

  localparam int NLEV = count_levels(NPP);

  // Rows of a (WIDTH+1)x(WIDTH+1) signed product; the sign row of b is added as ~A<<W plus 1<<W.
  function automatic rows_t gen_pp(input logic [WIDTH:0] ax, input logic [WIDTH:0] bx);
    rows_t         r;
    logic [PW-1:0] as;
    r  = '0;
    as = {{(PW-WIDTH-1){ax[WIDTH]}}, ax};
    for (int i = 0; i < WIDTH; i++)
      if (bx[i]) r[i] = as << i;
    if (bx[WIDTH]) begin
      r[WIDTH]   = ~as << WIDTH;
      r[WIDTH+1] = PW'(1) << WIDTH;
    end
    return r;
  endfunction

  // Applies tree levels [lo,hi); row counts per level follow from NPP, so layout is stable across stages.
  function automatic rows_t reduce(input rows_t r, input int lo, input int hi);
    rows_t cur, nxt;
    int    n, g, rem;
    cur = r;
    n   = NPP;
    for (int l = 0; l < NLEV; l++) begin
      g   = n / 3;
      rem = n % 3;
      nxt = '0;
      for (int j = 0; j < NPP/3; j++)
        if (j < g) begin
          nxt[2*j]   = cur[3*j] ^ cur[3*j+1] ^ cur[3*j+2];
          nxt[2*j+1] = ((cur[3*j] & cur[3*j+1]) | (cur[3*j] & cur[3*j+2]) |
                        (cur[3*j+1] & cur[3*j+2])) << 1;
        end
      for (int j = 0; j < 2; j++)
        if (j < rem) nxt[2*g+j] = cur[3*g+j];
      if (l >= lo && l < hi) cur = nxt;
      n = 2*g + rem;
    end
    return cur;
  endfunction

  function automatic logic [WIDTH-1:0] tail(input rows_t r, input logic [1:0] o);
    rows_t         fin;
    logic [HW-1:0] p;
    fin = reduce(r, (STAGES-1)*NLEV/STAGES, NLEV);
    p   = HW'(fin[0] + fin[1]);
    return (o == 2'b00) ? p[WIDTH-1:0] : p[HW-1:WIDTH];
  endfunction

  logic              adv, acc, byp;
  logic              a_sx, b_sx;
  logic [WIDTH:0]    ax, bx;
  logic [STAGES:1]   vld_q, vld_d;
  logic [STAGES:0]   vld;
  logic [WIDTH-1:0]  result_q, result_d, res_d;
  rows_t             st_rows [STAGES];
  logic [1:0]        st_op   [STAGES];

  assign a_sx = (op == 2'b01) || (op == 2'b10);
  assign b_sx = (op == 2'b01);
  assign ax   = {a_sx & a[WIDTH-1], a};
  assign bx   = {b_sx & b[WIDTH-1], b};

  assign st_rows[0] = gen_pp(ax, bx);
  assign st_op[0]   = op;

  for (genvar k = 0; k < STAGES-1; k++) begin : g_stage
    localparam int LO = k*NLEV/STAGES;
    localparam int HI = (k+1)*NLEV/STAGES;
    rows_t      rows_q;
    logic [1:0] op_q;
    always_ff @(posedge clk) begin
      if (adv) begin
        rows_q <= reduce(st_rows[k], LO, HI);
        op_q   <= st_op[k];
      end
    end
    assign st_rows[k+1] = rows_q;
    assign st_op[k+1]   = op_q;
  end

  assign res_d = tail(st_rows[STAGES-1], st_op[STAGES-1]);

  assign out_valid = vld[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign acc       = in_valid && adv;
  assign busy      = |vld_q;
  assign result    = result_q;

`ifdef MUL_EARLY_OUT_EN
  assign byp = acc && !busy && (a == '0 || b == '0);
`else
  assign byp = 1'b0;
`endif

  assign vld = {vld_q, acc && !byp};

  always_comb begin
    vld_d    = vld_q;
    result_d = result_q;
    if (adv) begin
      vld_d         = vld[STAGES-1:0];
      vld_d[STAGES] = vld[STAGES-1] | byp;
      result_d      = vld[STAGES-1] ? res_d : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q    <= '0;
      result_q <= '0;
    end else begin
      vld_q    <= vld_d;
      result_q <= result_d;
    end
  end
endmodule

// File: doc/mul_pipe.md
# mul_pipe

Parametrised, pipelined integer multiplier for the M-extension datapath. Evaluates MUL, MULH, MULHSU and MULHU with a Wallace-tree partial-product reduction, split across a configurable number of register stages. It accepts one operation per cycle through a valid/ready handshake and supports full back-pressure. It sits between the decode/issue logic and the EX writeback mux, and replaces the single-cycle combinational multiplier.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 8, even)
- STAGES, 3, cycles from accept to result (≥ 1); reduction levels are split evenly across stages, with the final carry-propagate add in the last stage
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operation present on op/a/b
- in_ready  out  1  block can accept this cycle
- op  in  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
- a  in  WIDTH  rs1 operand
- b  in  WIDTH  rs2 operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  selected half of the 2·WIDTH product
- busy  out  1  any stage holds a valid operation

## Operation
- Operand extension:
  - a is sign-extended to WIDTH+1 bits for op 01 and 10; zero-extended otherwise.
  - b is sign-extended for op 01 only.
  - The product is computed as a (2·WIDTH+2)-bit two's-complement value.
  - MUL returns bits [WIDTH-1:0]; the other ops return bits [2·WIDTH-1:WIDTH].
- Pipeline:
  - STAGES register slices, each with a valid bit, and op carried alongside the data.
  - Global advance enable: adv = !out_valid || out_ready.
  - When adv = 0, every stage holds, including invalid bubbles.
- Handshake:
  - in_ready = adv.
  - A transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - result and out_valid are stable while out_valid && !out_ready.
- Ordering: results leave strictly in acceptance order.
- busy is the OR of all stage valid bits.
- Reset:
  - rst_n = 0 at a clock edge clears all valid bits; in-flight operations are discarded.
  - result is forced to 0.
  - in_ready is 1 from the first cycle after reset deasserts.
- Reset values: out_valid 0, result 0, busy 0, in_ready 1.

## Timing
- Latency is exactly STAGES cycles:
  - An operation accepted at edge N has out_valid = 1 after edge N+STAGES, provided no stall occurred.
  - Each stall cycle adds one cycle.
- Throughput: one operation per cycle while out_ready = 1.
- Simultaneous accept and retire in the same cycle with a full pipe is legal and loses no data.
- in_ready depends combinationally on out_ready; there is no other combinational in→out path.
- Stall boundary: with all STAGES slots valid and out_ready = 0, in_ready = 0. When out_ready rises, in_ready rises in the same cycle.

## Configuration
- MUL_EARLY_OUT_EN:
  - Defined: an operation with a == 0 or b == 0, accepted while busy == 0, bypasses the tree. It produces result 0 with out_valid after 1 cycle. Otherwise the normal path is used, so ordering is preserved. The bypass slot respects the same stall rule.
  - Undefined: every operation takes STAGES cycles and no bypass logic exists.

## Test plan
- Default parameters, a = b = 0xFFFFFFFF, issue ops 00/01/10/11 back-to-back with out_ready = 1 → results 0x00000001, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE on four consecutive cycles, starting 3 cycles after the first accept.
- a = 0x00009129, b = 0x00009111: MUL → 0x5241DCB9; MULHU → 0x00000000. a = b = 0x80000000: MULH → 0x40000000; MUL → 0x00000000.
- Back-pressure: stream 6 ops, hold out_ready = 0 for 4 cycles once the first result appears. Required: in_ready drops once the pipe is full, result stays frozen, all 6 results emerge in order with none lost.
- Reset mid-flight: accept 2 ops, assert rst_n = 0 for one edge. Required: out_valid 0, result 0, busy 0 on the next cycle; neither op is ever output.
- With MUL_EARLY_OUT_EN defined, from idle, a = 0, b = 0x1234 → result 0 after 1 cycle. Repeat while another op is in flight → 0 emerges after that op, in order.
- WIDTH = 16, STAGES = 1, random signed/unsigned sweep of 10k ops against a reference model → all match, latency 1.
